timer_array: RTL

//  Parametrised multi-channel memory-mapped timer peripheral for the MIPS CPU bus. Successor to the single timer.

---
 rtl/timer_pkg.sv | 22 ++
 rtl/timer_channel.sv | 120 ++++++++++++
 rtl/timer_array.sv | 77 +++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared register offsets, TCON bit positions and the TCON bundle for timer_array.
package timer_pkg;

    localparam logic [3:0] OFF_TH    = 4'h0;
    localparam logic [3:0] OFF_TL    = 4'h4;
    localparam logic [3:0] OFF_TCON  = 4'h8;
    localparam logic [3:0] OFF_PSC   = 4'hC;
    localparam int         CH_STRIDE = 16;

    localparam int EN_B  = 0;
    localparam int IE_B  = 1;
    localparam int IRQ_B = 2;
    localparam int OS_B  = 3;

    typedef struct packed {
        logic os;
        logic irq;
        logic ie;
        logic en;
    } tcon_t;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: TH/TL/TCON state, tick, reload on all-ones, W1C status.
// Optional prescaler built only when TIMER_PRESCALER_EN is defined.
module timer_channel
    import timer_pkg::*;
#(
    parameter int          WIDTH  = 32,
    parameter logic [31:0] TH_RST = 32'h0000_0004
) (
    input  logic        clk_in,
    input  logic        reset_n,
    input  logic        we_th,
    input  logic        we_tl,
    input  logic        we_tcon,
`ifdef TIMER_PRESCALER_EN
    input  logic        we_psc,
`endif
    input  logic [31:0] wdata,
    input  logic [3:0]  rd_off,
    output logic [31:0] rd_data,
    output logic        irq_st
);

    localparam logic [WIDTH-1:0] TH_INIT = TH_RST[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] th_q, th_d;
    logic [WIDTH-1:0] tl_q, tl_d;
    tcon_t            tcon_q, tcon_d;
    logic             tick;
    logic             ovf;

`ifdef TIMER_PRESCALER_EN
    logic [15:0] psc_q, psc_d;
    logic [15:0] pcnt_q, pcnt_d;

    assign tick = tcon_q.en && (pcnt_q == psc_q);

    always_comb begin
        psc_d = we_psc ? wdata[15:0] : psc_q;
        if (!tcon_q.en || we_psc) begin
            pcnt_d = '0;
        end else if (pcnt_q == psc_q) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            psc_q  <= '0;
            pcnt_q <= '0;
        end else begin
            psc_q  <= psc_d;
            pcnt_q <= pcnt_d;
        end
    end
`else
    assign tick = tcon_q.en;
`endif

    assign ovf = tick && (tl_q == '1);

    always_comb begin
        th_d = we_th ? wdata[WIDTH-1:0] : th_q;

        tl_d = tl_q;
        if (tick) begin
            tl_d = ovf ? th_q : tl_q + ONE;
        end
        if (we_tl) begin
            tl_d = wdata[WIDTH-1:0];
        end

        tcon_d = tcon_q;
        if (ovf && tcon_q.os) begin
            tcon_d.en = 1'b0;
        end
        if (we_tcon) begin
            tcon_d.en = wdata[EN_B];
            tcon_d.ie = wdata[IE_B];
            tcon_d.os = wdata[OS_B];
            if (wdata[IRQ_B]) begin
                tcon_d.irq = 1'b0;
            end
        end
        // Set after the W1C so an overflow in the clear cycle is kept.
        if (ovf && tcon_q.ie) begin
            tcon_d.irq = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            th_q   <= TH_INIT;
            tl_q   <= '0;
            tcon_q <= '0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_off)
            OFF_TH:   rd_data[WIDTH-1:0] = th_q;
            OFF_TL:   rd_data[WIDTH-1:0] = tl_q;
            OFF_TCON: rd_data[3:0]       = tcon_q;
`ifdef TIMER_PRESCALER_EN
            OFF_PSC:  rd_data[15:0]      = psc_q;
`endif
            default:  rd_data = '0;
        endcase
    end

    assign irq_st = tcon_q.irq;

endmodule

// File: rtl/timer_array.sv
// Multi-channel memory-mapped timer: address decode, registered read mux, IRQ OR.
// Define TIMER_PRESCALER_EN to add a per-channel 16-bit prescaler at offset 0xC.
module timer_array
    import timer_pkg::*;
#(
    parameter int          N_CH   = 2,
    parameter int          WIDTH  = 32,
    parameter logic [31:0] TH_RST = 32'h0000_0004
) (
    input  logic            clk_in,
    input  logic            reset_n,
    input  logic            wr_en,
    input  logic            rd_en,
    input  logic [7:0]      addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic [N_CH-1:0] irq_vec,
    output logic            irq
);

    logic [3:0]  ch_sel;
    logic [3:0]  off;
    logic        hit;
    logic [31:0] ch_rd [N_CH];
    logic [31:0] rdata_q, rdata_d;

    assign ch_sel = addr[7:4];
    assign off    = addr[3:0] & 4'hC;
    assign hit    = ({24'b0, addr} < 32'(N_CH * CH_STRIDE));

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic sel;
        assign sel = hit && (ch_sel == 4'(c));

        timer_channel #(
            .WIDTH  (WIDTH),
            .TH_RST (TH_RST)
        ) u_ch (
            .clk_in  (clk_in),
            .reset_n (reset_n),
            .we_th   (wr_en && sel && (off == OFF_TH)),
            .we_tl   (wr_en && sel && (off == OFF_TL)),
            .we_tcon (wr_en && sel && (off == OFF_TCON)),
`ifdef TIMER_PRESCALER_EN
            .we_psc  (wr_en && sel && (off == OFF_PSC)),
`endif
            .wdata   (wdata),
            .rd_off  (off),
            .rd_data (ch_rd[c]),
            .irq_st  (irq_vec[c])
        );
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            rdata_d = '0;
            for (int c = 0; c < N_CH; c++) begin
                if (hit && (ch_sel == 4'(c))) begin
                    rdata_d = ch_rd[c];
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
    assign irq   = |irq_vec;

endmodule
